// File: rtl/seg7_frame_capture.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the displayed hex nibbles,
// qualifying each digit by dwell stability and emitting one packed frame per full scan.
module seg7_frame_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   frame_value,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  frame_valid,
    output logic                  capture_pulse
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned VAL_W = 4 * DIGITS;

    localparam logic [1:0] BLANK = 2'd0;
    localparam logic [1:0] DWELL = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    logic [6:0]        seg_meta, s_seg, prev_seg;
    logic [DIGITS-1:0] an_meta, s_an, prev_an, low;
    logic [1:0]        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              active, same, capture, err;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nib;
    logic [VAL_W-1:0]  stage_value;
    logic [DIGITS-1:0] stage_err, mask, mask_next;

    // Inverse of the segment encoder; {err, nibble}
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h01:   decode = 5'h00;
            7'h4F:   decode = 5'h01;
            7'h12:   decode = 5'h02;
            7'h06:   decode = 5'h03;
            7'h4C:   decode = 5'h04;
            7'h24:   decode = 5'h05;
            7'h20:   decode = 5'h06;
            7'h0F:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h0C:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h60:   decode = 5'h0B;
            7'h31:   decode = 5'h0C;
            7'h42:   decode = 5'h0D;
            7'h30:   decode = 5'h0E;
            7'h38:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign {err, nib} = decode(s_seg);

    // A sample is active only when exactly one strobe is low
    always_comb begin
        low    = ~s_an;
        active = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
        same   = (s_an == prev_an) && (s_seg == prev_seg);
        idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (low[i]) idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (!active) begin
            state_next = BLANK;
        end else if (state == BLANK || !same) begin
            if (STABLE_CYCLES == 1) begin
                capture    = 1'b1;
                state_next = HELD;
            end else begin
                cnt_next   = CNT_W'(1);
                state_next = DWELL;
            end
        end else if (state == DWELL) begin
            if (cnt != CNT_W'(STABLE_CYCLES)) cnt_next = cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == CNT_W'(STABLE_CYCLES)) begin
                capture    = 1'b1;
                state_next = HELD;
            end
        end else if (state != HELD) begin
            state_next = BLANK;
        end
    end

    // Completion clears the mask, but a capture on that same edge opens the next frame
    always_comb begin
        mask_next = (&mask) ? '0 : mask;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && idx == IDX_W'(i)) mask_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta      <= '1;
            s_seg         <= '1;
            prev_seg      <= '1;
            an_meta       <= '1;
            s_an          <= '1;
            prev_an       <= '1;
            stage_value   <= '0;
            stage_err     <= '0;
            mask          <= '0;
            frame_value   <= '0;
            frame_err     <= '0;
            frame_valid   <= 1'b0;
            capture_pulse <= 1'b0;
        end else begin
            seg_meta      <= seg_n;
            s_seg         <= seg_meta;
            prev_seg      <= s_seg;
            an_meta       <= an_n;
            s_an          <= an_meta;
            prev_an       <= s_an;
            mask          <= mask_next;
            capture_pulse <= capture;
            frame_valid   <= &mask;
            if (&mask) begin
                frame_value <= stage_value;
                frame_err   <= stage_err;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && idx == IDX_W'(i)) begin
                    stage_value[4*i +: 4] <= nib;
                    stage_err[i]          <= err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed self-checking bench for seg7_frame_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_frame_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] frame_value;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        capture_pulse;

    int checks = 0;
    int errors = 0;
    int cap_cnt = 0;
    int fv_cnt = 0;
    int c0, f0;

    seg7_frame_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_n         (seg_n),
        .an_n          (an_n),
        .frame_value   (frame_value),
        .frame_err     (frame_err),
        .frame_valid   (frame_valid),
        .capture_pulse (capture_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture_pulse === 1'b1) cap_cnt <= cap_cnt + 1;
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig(input int i, input logic [6:0] seg, input int n);
        step(~(4'b0001 << i), seg, n);
    endtask

    task automatic blank(input int n);
        step(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input int d0, input int d1, input int d2,
                        input int d3);
        dig(0, s0, d0);
        dig(1, s1, d1);
        dig(2, s2, d2);
        dig(3, s3, d3);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        blank(2);
    endtask

    initial begin
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 7'h7F;
        @(posedge clk);
        #1;
        check("rst_value", 32'(frame_value), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_capture", 32'(capture_pulse), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        blank(2);

        // Basic scan: digits 3,4,5,6
        c0 = cap_cnt; f0 = fv_cnt;
        scan(7'h06, 7'h4C, 7'h24, 7'h20, 8, 8, 8, 8);
        blank(6);
        check("scan_caps", 32'(cap_cnt - c0), 32'd4);
        check("scan_frames", 32'(fv_cnt - f0), 32'd1);
        check("scan_value", 32'(frame_value), 32'h6543);
        check("scan_err", 32'(frame_err), 32'h0);

        // Short dwell on digit 2 never qualifies, then exactly STABLE_CYCLES does
        do_reset();
        c0 = cap_cnt; f0 = fv_cnt;
        scan(7'h01, 7'h4F, 7'h12, 7'h06, 8, 8, 3, 8);
        scan(7'h01, 7'h4F, 7'h12, 7'h06, 8, 8, 3, 8);
        blank(6);
        check("short_caps", 32'(cap_cnt - c0), 32'd6);
        check("short_frames", 32'(fv_cnt - f0), 32'd0);
        scan(7'h01, 7'h4F, 7'h12, 7'h06, 8, 8, 4, 8);
        blank(6);
        check("edge_frames", 32'(fv_cnt - f0), 32'd1);
        check("edge_value", 32'(frame_value), 32'h3210);
        check("edge_caps", 32'(cap_cnt - c0), 32'd10);

        // Illegal pattern on digit 1
        do_reset();
        f0 = fv_cnt;
        scan(7'h01, 7'h7F, 7'h01, 7'h01, 8, 8, 8, 8);
        blank(6);
        check("illegal_frames", 32'(fv_cnt - f0), 32'd1);
        check("illegal_err", 32'(frame_err), 32'h2);
        check("illegal_value", 32'(frame_value), 32'h0000);

        // Overlapping strobes and blanking restart the dwell count
        do_reset();
        c0 = cap_cnt;
        step(4'b1100, 7'h06, 10);
        blank(10);
        check("overlap_caps", 32'(cap_cnt - c0), 32'd0);
        dig(0, 7'h06, 3);
        blank(3);
        dig(0, 7'h06, 3);
        step(4'b1100, 7'h06, 2);
        dig(0, 7'h06, 3);
        blank(6);
        check("restart_caps", 32'(cap_cnt - c0), 32'd0);
        dig(0, 7'h06, 4);
        blank(6);
        check("restart_then_cap", 32'(cap_cnt - c0), 32'd1);

        // Long dwell captures once
        do_reset();
        c0 = cap_cnt;
        dig(0, 7'h06, 40);
        blank(6);
        check("held_caps", 32'(cap_cnt - c0), 32'd1);

        // Reset mid-frame discards partial captures
        do_reset();
        f0 = fv_cnt;
        scan(7'h06, 7'h4C, 7'h24, 7'h20, 8, 8, 8, 8);
        blank(6);
        check("pre_rst_value", 32'(frame_value), 32'h6543);
        dig(0, 7'h01, 8);
        dig(1, 7'h4F, 8);
        dig(2, 7'h12, 8);
        rst = 1'b1;
        #1;
        check("midrst_value", 32'(frame_value), 32'h0);
        check("midrst_capture", 32'(capture_pulse), 32'h0);
        blank(4);
        check("midrst_valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        blank(2);
        check("midrst_frames", 32'(fv_cnt - f0), 32'd1);
        scan(7'h0C, 7'h08, 7'h60, 7'h31, 8, 8, 8, 8);
        blank(6);
        check("post_rst_frames", 32'(fv_cnt - f0), 32'd2);
        check("post_rst_value", 32'(frame_value), 32'hCBA9);
        check("post_rst_err", 32'(frame_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_frame_capture.md
Name: seg7_frame_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder.
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode strobes) and recovers the displayed hex nibbles.
- Used as an on-chip display loopback/self-check and as a bench monitor for display drivers.
- Qualifies each digit by dwell stability, inverse-decodes the pattern, flags illegal patterns, and emits one packed frame once every digit has been captured.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- seg_n  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- an_n  input  DIGITS  digit strobes, active-low; bit i selects digit i
- frame_value  output  4*DIGITS  decoded nibbles; digit i at [4i+3:4i]
- frame_err  output  DIGITS  bit i set if digit i held an illegal pattern in the frame
- frame_valid  output  1  one-cycle pulse; frame_value/frame_err updated on the same cycle
- capture_pulse  output  1  one-cycle pulse for each individual digit capture (debug)

Behaviour:
- Reset: async, active-high. Clears all outputs to 0, the synchronizers to all-ones (idle bus), the staging registers, the captured mask, and the stability counter. FSM enters BLANK.
- Synchronization:
  - seg_n and an_n each pass through 2 flops.
  - All logic below uses the synchronized values s_seg and s_an.
- Digit select: a sample is "active" only if exactly one bit of s_an is 0. Zero or multiple low bits means blanking.
- Inverse decode table (s_seg hex -> nibble): 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 0C->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F. Any other pattern is illegal: nibble 0, err=1.
- FSM states:
  - BLANK: sample not active. On an active sample, load cnt=1 and go to DWELL.
  - DWELL: if the sample equals the previous sample (same s_an and s_seg), cnt increments. When the incremented value would reach STABLE_CYCLES, capture and go to HELD. A changed active sample reloads cnt=1 and stays in DWELL. A blank sample goes to BLANK.
  - HELD: stay while the sample is unchanged; no re-capture. A changed active sample loads cnt=1 and goes to DWELL. A blank sample goes to BLANK.
  - STABLE_CYCLES=1: capture happens on the first active sample cycle (BLANK->HELD directly).
- Capture, at the clock edge:
  - Write the nibble and err bit into staging slot i.
  - Set mask bit i.
  - Pulse capture_pulse.
  - Recapturing slot i within the same frame overwrites that slot.
- Frame completion:
  - On the cycle after the mask becomes all ones, pulse frame_valid and copy staging into frame_value/frame_err.
  - Clear the mask in that same cycle.
  - A capture in the completion cycle is recorded into the new frame.
- Latency:
  - Input change to first sync sample: 2 cycles.
  - First stable sample to capture_pulse: STABLE_CYCLES cycles.
  - Final capture to frame_valid: +1 cycle.
- cnt width: clog2(STABLE_CYCLES+1); saturates, never wraps.
- Reset asserted mid-frame discards partial captures; no frame_valid is issued for the partial frame.
- Outputs hold their last frame until the next frame_valid.

Test Plan:
- DIGITS=4, STABLE_CYCLES=4. Scan digits 0..3 showing seg 06,4C,24,20, each strobe held 8 cycles. -> Exactly 4 capture_pulse; one frame_valid with frame_value=16'h6543, frame_err=0.
- Digit 2 strobe held only 3 cycles per visit, others 8 cycles. -> No capture of digit 2, no frame_valid. Then raise digit 2 dwell to 4 cycles -> frame_valid asserted.
- Digit 1 shows illegal pattern 7F; others legal 01. -> frame_err=4'b0010, frame_value nibble1=0.
- Two strobes low simultaneously (an_n=4'b1100), then all-high blanking between digits. -> No capture during the overlap or blanking; cnt restarts on the next active sample.
- Digit 0 held 40 cycles with a constant pattern. -> Exactly one capture_pulse for that dwell (HELD suppresses repeats).
- Assert rst after 3 of 4 digits are captured, then do a full scan. -> Outputs 0 during reset; the next frame_valid carries only post-reset data.
